addsub_serial_sat: RTL
======================

Name: addsub_serial_sat

Overview:
Parametrised two's-complement add/subtract unit, successor to the team's 4-bit combinational add/sub block. It processes operands digit-serially, CHUNK bits per clock, LSB first, trading latency for a short carry path. It adds a valid/ready handshake on both sides, signed-overflow detection, optional saturation and a zero flag. It sits between operand registers and the result bus in datapaths wider than the 4-bit unit supports.

Parameters:
WIDTH, 16, operand/result width in bits; must be >= 2.
CHUNK, 4, bits added per cycle; WIDTH % CHUNK must be 0; CHUNK = WIDTH gives a 1-cycle compute.

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands
x  input  WIDTH  operand A, two's complement
y  input  WIDTH  operand B, two's complement
sub  input  1  0: x+y; 1: x-y (computed as x + ~y + 1)
sat  input  1  1: clamp on signed overflow
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
c_out  output  1  raw carry out of MSB; for subtract, 1 = no borrow
ovf  output  1  signed overflow of the unsaturated result
zero  output  1  final sum (after saturation) == 0

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset: state IDLE; in_ready=1; out_valid=0; sum=0; c_out=0; ovf=0; zero=0; chunk counter=0.
- Reset mid-operation (CALC or DONE): the operation is aborted and the result discarded. All reset values apply after that edge.
- N = WIDTH/CHUNK.
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready at an edge, latch x, yi = y ^ {WIDTH{sub}}, carry = sub, sub and sat. Go to CALC with counter=0.
- CALC:
  - in_ready=0; in_valid is ignored.
  - Each edge: {carry, r_chunk} = x_chunk[i] + yi_chunk[i] + carry, where i = counter. r_chunk is written to result bits [i*CHUNK +: CHUNK].
  - Counter increments. After the edge that processes i = N-1, go to DONE.
- Latency: if the accept edge is k, out_valid is first high after edge k+N.
- Finalisation, computed on the last CALC edge and registered:
  - c_out = final carry.
  - ovf = (x[MSB] == yi[MSB]) && (raw[MSB] != x[MSB]).
  - If sat && ovf, sum = x[MSB] ? {1'b1, {WIDTH-1{1'b0}}} : {1'b0, {WIDTH-1{1'b1}}}. Otherwise sum = raw.
  - zero = (sum == 0).
  - c_out is unaffected by sat.
- DONE:
  - out_valid=1; in_ready=0.
  - sum, c_out, ovf and zero are held stable until out_valid && out_ready at an edge, then go to IDLE.
- Minimum throughput is one result per N+2 cycles. A new acceptance is possible one cycle after output handshake; there is no overlap.
- Outputs hold their last values in IDLE; consumers qualify with out_valid.
- Arithmetic is modulo 2^WIDTH. The carry chain crosses chunk boundaries only through the carry register.

Test Plan:
(All with WIDTH=16, CHUNK=4, so N=4.)
1. Add: accept 0x1234 + 0x0FF0, sub=0 -> sum=0x2224, c_out=0, ovf=0, zero=0. out_valid rises exactly 4 cycles after the accept edge.
2. Subtract: 0x0005 - 0x0007 -> 0xFFFE, c_out=0, ovf=0. Then 0x0007 - 0x0005 -> 0x0002, c_out=1.
3. Overflow/saturation:
   - 0x7FFF + 0x0001, sat=0 -> 0x8000, ovf=1.
   - Same with sat=1 -> 0x7FFF, ovf=1.
   - 0x8000 - 0x0001, sat=1 -> 0x8000, ovf=1.
4. Cross-chunk carry: 0xFFFF + 0x0001 -> sum=0x0000, c_out=1, ovf=0, zero=1. Also run with CHUNK=16, which must give the same result in 1 cycle.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum and flags stable, in_ready=0. A new in_valid pulse in that window is not accepted. After out_ready=1, in_ready=1 on the next cycle.
6. Reset after 2 CALC cycles -> after that edge: IDLE, in_ready=1, out_valid=0, sum=0, all flags 0. No result is emitted.

Source files
------------

// File: rtl/addsub_serial_sat.sv
// addsub_serial_sat
//   Digit-serial two's-complement add/subtract unit with valid/ready handshake
//   on both sides, signed-overflow detection, optional saturation and a zero
//   flag. Operands are consumed CHUNK bits per clock, LSB first, so the carry
//   path is only CHUNK bits long; chunks are linked through a carry register.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits added per clock (WIDTH % CHUNK == 0); CHUNK == WIDTH is 1 cycle
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand set valid
//   in_ready   unit can accept operands (IDLE only)
//   x, y       operands, two's complement
//   sub        0: x+y, 1: x-y (x + ~y + 1)
//   sat        clamp result to the signed range on overflow
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   sum        result (saturated if requested)
//   c_out      raw carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        signed overflow of the unsaturated result
//   zero       final sum == 0
module addsub_serial_sat #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  // Operand shift registers: the chunk in flight always sits in the low bits,
  // so no variable part-selects are needed. The operand sign bits are kept
  // separately since the shifted copies lose them.
  logic [WIDTH-1:0] x_q, yi_q, raw_q;
  logic             x_msb_q, yi_msb_q;
  logic             carry_q;
  logic             sat_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] sum_q;
  logic             c_out_q, ovf_q, zero_q;

  logic             accept;
  logic             release_res;
  logic             last_chunk;

  logic [CHUNK:0]   chunk_add;
  logic [WIDTH-1:0] raw_d;
  logic             ovf_d;
  logic [WIDTH-1:0] sum_d;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)      state_d = CALC;
      CALC:    if (last_chunk)  state_d = DONE;
      DONE:    if (release_res) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;
  assign last_chunk  = (state_q == CALC) && (cnt_q == LAST);

  // ---------------------------------------------------------------------------
  // Datapath: one CHUNK-bit addition per CALC cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    chunk_add = {1'b0, x_q[CHUNK-1:0]} + {1'b0, yi_q[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry_q};
    // New chunk enters at the top; after N shifts raw_d holds the full result.
    raw_d = (raw_q >> CHUNK) | (WIDTH'(chunk_add[CHUNK-1:0]) << (WIDTH - CHUNK));
    ovf_d = (x_msb_q == yi_msb_q) && (raw_d[WIDTH-1] != x_msb_q);
    sum_d = raw_d;
    if (sat_q && ovf_d) begin
      sum_d = x_msb_q ? SAT_NEG : SAT_POS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      yi_q     <= '0;
      raw_q    <= '0;
      x_msb_q  <= 1'b0;
      yi_msb_q <= 1'b0;
      carry_q  <= 1'b0;
      sat_q    <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      if (accept) begin
        x_q      <= x;
        yi_q     <= y ^ {WIDTH{sub}};
        raw_q    <= '0;
        x_msb_q  <= x[WIDTH-1];
        yi_msb_q <= y[WIDTH-1] ^ sub;
        carry_q  <= sub;
        sat_q    <= sat;
        cnt_q    <= '0;
      end else if (state_q == CALC) begin
        x_q     <= x_q >> CHUNK;
        yi_q    <= yi_q >> CHUNK;
        raw_q   <= raw_d;
        carry_q <= chunk_add[CHUNK];
        cnt_q   <= cnt_q + 1'b1;
        if (last_chunk) begin
          sum_q   <= sum_d;
          c_out_q <= chunk_add[CHUNK];
          ovf_q   <= ovf_d;
          zero_q  <= (sum_d == '0);
        end
      end
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule
